// File: rtl/chan_sel_mux_if.sv
// chan_sel_mux_if: bundles the N producer streams, the mode/select controls
// and the single consumer stream of chan_sel_mux.
//   master : the surrounding system (drives in_data/in_valid/mode/sel/out_ready)
//   slave  : the multiplexer (drives in_ready/out_data/out_chan/out_valid)
interface chan_sel_mux_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/chan_sel_mux.sv
// chan_sel_mux: registered N-to-1 channel multiplexer with valid/ready
// handshakes on every channel and on the output.
//   mode = 0 : manual, the channel named by sel is granted
//   mode = 1 : round-robin among valid channels, starting from ptr
// One output beat is held in a register so downstream stalls lose nothing.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : chan_sel_mux_if.slave (inputs, in_ready, registered outputs)
module chan_sel_mux #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input logic          clk,
  input logic          rst_n,
  chan_sel_mux_if.slave bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  chan_q;
  logic [SELW-1:0]  ptr;

  logic             load_en;
  logic             grant_valid;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;
  logic             grant_in_valid;
  logic [NCH-1:0]   ready_d;
  logic             xfer;

  // Register may accept a new beat when empty or when the held beat drains now.
  assign load_en = (state == EMPTY) || bus.out_ready;

  // Grant selection. Round-robin scans ptr..NCH-1 first, then 0..ptr-1, which
  // is the modulo-NCH search from ptr without a variable-width modulo.
  // NOTE: every variable written here gets a default first, so no latch is
  // inferred on paths where no channel matches.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (!bus.mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.sel == SELW'(i)) begin
          grant_valid = 1'b1;
          grant       = bus.sel;
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!grant_valid && SELW'(i) >= ptr && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SELW'(i);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!grant_valid && SELW'(i) < ptr && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SELW'(i);
        end
      end
    end
  end

  // Decode the grant into per-channel ready and pick the granted data/valid.
  // Manual mode raises ready on sel regardless of that channel's valid.
  always_comb begin
    ready_d        = '0;
    grant_data     = '0;
    grant_in_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        grant_data     = bus.in_data[i*WIDTH +: WIDTH];
        grant_in_valid = bus.in_valid[i];
        ready_d[i]     = load_en && grant_valid;
      end
    end
  end

  assign xfer = load_en && grant_valid && grant_in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      data_q <= '0;
      chan_q <= '0;
      ptr    <= '0;
    end else if (load_en) begin
      if (xfer) begin
        state  <= FULL;
        data_q <= grant_data;
        chan_q <= grant;
        // Only round-robin transfers advance the fairness pointer.
        if (bus.mode) begin
          ptr <= (grant == SELW'(NCH-1)) ? '0 : grant + 1'b1;
        end
      end else begin
        state <= EMPTY;
      end
    end
  end

  assign bus.in_ready  = ready_d;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = (state == FULL);

endmodule

// File: tb/tb_chan_sel_mux.sv
// tb_chan_sel_mux: directed stimulus for chan_sel_mux (WIDTH=4, NCH=4).
// The stimulus process pushes the expected {chan, data} of every beat it
// expects to be accepted; a monitor pops and compares each beat the consumer
// takes. Direct checks cover reset, in_ready, holds and asynchronous reset.
module tb_chan_sel_mux;

  localparam int WIDTH = 4;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic clk;
  logic rst_n;

  chan_sel_mux_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

  chan_sel_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [SELW+WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]      chd[NCH] = '{4'd5, 4'd9, 4'd15, 4'd2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic [SELW-1:0] c);
    exp_q.push_back({c, d});
  endtask

  // Monitor: a beat is consumed at the next rising edge when valid and ready
  // are both high mid-cycle; inputs only change just after rising edges.
  initial begin
    logic [SELW+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {bus.out_chan, bus.out_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("beat_chan_data", {bus.out_chan, bus.out_data}, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random inputs
    rst_n         = 1'b0;
    bus.mode      = 1'($urandom);
    bus.sel       = SELW'($urandom);
    bus.in_valid  = NCH'($urandom);
    bus.in_data   = (NCH*WIDTH)'($urandom);
    bus.out_ready = 1'($urandom);
    repeat (3) tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_chan", bus.out_chan, 0);

    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    bus.in_data   = {chd[3], chd[2], chd[1], chd[0]};
    bus.mode      = 1'b1;
    bus.sel       = '0;
    rst_n         = 1'b1;
    tick();
    check("post_rst_valid", bus.out_valid, 0);

    // Round-robin fairness, all valid: 0,1,2,3,0,1,2,3
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_all_ready", bus.in_ready, 32'(1 << (k % 4)));
      push(chd[k % 4], SELW'(k % 4));
      tick();
    end

    // Only ch1 and ch3 valid: 1,3,1 (ptr ends at 2)
    bus.in_valid = 4'b1010;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rr_pair_ready", bus.in_ready, (k % 2) ? 32'b1000 : 32'b0010);
      if (k % 2) push(chd[3], 2'd3);
      else       push(chd[1], 2'd1);
      tick();
    end

    // No valid inputs: no grant, register drains, ptr stays 2
    bus.in_valid = 4'b0000;
    #1;
    check("rr_none_ready", bus.in_ready, 0);
    tick();
    tick();
    check("rr_none_valid", bus.out_valid, 0);
    bus.in_valid = 4'b1111;
    #1;
    check("rr_ptr_kept", bus.in_ready, 32'b0100);
    push(chd[2], 2'd2);
    tick();

    // ptr=3 with only ch0 valid: grant ch0, ptr wraps to 1
    bus.in_valid = 4'b0001;
    #1;
    check("rr_wrap_ready", bus.in_ready, 32'b0001);
    push(chd[0], 2'd0);
    tick();
    bus.in_valid = 4'b1111;
    #1;
    check("rr_ptr_one", bus.in_ready, 32'b0010);
    push(chd[1], 2'd1);
    tick();

    // Backpressure: hold 9/ch1 for 3 cycles
    bus.out_ready = 1'b0;
    #1;
    check("bp_ready", bus.in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_data", bus.out_data, 9);
      check("bp_chan", bus.out_chan, 1);
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 32'b0100);
    push(chd[2], 2'd2);
    tick();
    check("bp_reload_data", bus.out_data, 15);
    check("bp_reload_chan", bus.out_chan, 2);

    // Manual sweep sel 0..3
    bus.mode     = 1'b0;
    bus.in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      bus.sel = SELW'(s);
      #1;
      check("man_ready", bus.in_ready, 32'(1 << s));
      push(chd[s], SELW'(s));
      tick();
    end

    // Manual sel=2 with ch2 not valid: ready still up, no transfer
    bus.sel      = 2'd2;
    bus.in_valid = 4'b1011;
    #1;
    check("man_nv_ready", bus.in_ready, 32'b0100);
    tick();
    check("man_nv_valid", bus.out_valid, 0);
    check("man_nv_data_hold", bus.out_data, 2);
    check("man_nv_chan_hold", bus.out_chan, 3);

    // Round-robin resumes from retained ptr=3
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    #1;
    check("rr_resume_ready", bus.in_ready, 32'b1000);
    push(chd[3], 2'd3);
    tick();

    // Mode 1->0 while FULL and stalled: held beat unchanged, next from sel
    bus.out_ready = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = 2'd1;
    #1;
    check("sw_ready_stall", bus.in_ready, 0);
    tick();
    check("sw_hold_data", bus.out_data, 2);
    check("sw_hold_chan", bus.out_chan, 3);
    bus.out_ready = 1'b1;
    #1;
    check("sw_sel_ready", bus.in_ready, 32'b0010);
    push(chd[1], 2'd1);
    tick();
    check("sw_next_chan", bus.out_chan, 1);

    // Asynchronous reset while FULL discards the held beat
    bus.out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_data", bus.out_data, 0);
    check("arst_chan", bus.out_chan, 0);
    exp_q.delete();
    tick();
    rst_n         = 1'b1;
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check("arst_first_grant", bus.in_ready, 32'b0001);
    push(chd[0], 2'd0);
    tick();
    bus.in_valid = 4'b0000;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
